// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder.
// Holds the FSM state encoding, the command bytes that open a write or a
// read transaction, and the 2-bit error codes reported on ERR_CODE.
package uart_cmd_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_SEND = 3'd5
  } state_e;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  localparam logic [1:0] ERR_CMD     = 2'b01;
  localparam logic [1:0] ERR_FRAME   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns a byte stream from a UART receiver into
// register-file write/read requests and returns read data to a UART
// transmitter.
//   Write: 0xAA, addr, data  -> one WR_EN pulse with ADDR/WR_DATA.
//   Read : 0xBB, addr        -> one RD_EN pulse, wait for RD_DATA_VLD,
//                               then one TX_D_VLD pulse with the data.
// Ports:
//   CLK, RST                    clock, async active-high reset
//   RX_P_DATA/RX_D_VLD          received byte and its valid pulse
//   PAR_ERR/STP_ERR             framing flags, qualified by RX_D_VLD
//   WR_EN/RD_EN/ADDR/WR_DATA    register-file request (registered)
//   RD_DATA/RD_DATA_VLD         register-file read return
//   TX_P_DATA/TX_D_VLD/TX_BUSY  transmitter feed
//   ERR_V/ERR_CODE              error pulse and sticky error code
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  PAR_ERR,
  input  logic                  STP_ERR,
  output logic                  WR_EN,
  output logic                  RD_EN,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  RD_DATA_VLD,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  ERR_V,
  output logic [1:0]            ERR_CODE
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  err_v_q, err_v_d;
  logic                  frame_err_s;

  // A received byte with a parity or stop error aborts any command in progress.
  assign frame_err_s = RX_D_VLD & (PAR_ERR | STP_ERR);

  // State, counter and all outputs are registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      addr_q     <= '0;
      wr_data_q  <= '0;
      tx_data_q  <= '0;
      err_code_q <= 2'b00;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_vld_q   <= 1'b0;
      err_v_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      tx_data_q  <= tx_data_d;
      err_code_q <= err_code_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      tx_vld_q   <= tx_vld_d;
      err_v_q    <= err_v_d;
    end
  end

  // Next-state and next-output logic; pulses default low, data holds.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    tx_data_d  = tx_data_q;
    err_code_d = err_code_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    tx_vld_d   = 1'b0;
    err_v_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR: begin
        if (frame_err_s) begin
          state_d    = ST_IDLE;
          err_v_d    = 1'b1;
          err_code_d = ERR_FRAME;
        end else if (RX_D_VLD) begin
          case (state_q)
            ST_IDLE: begin
              if (RX_P_DATA == DATA_WIDTH'(CMD_WR)) begin
                state_d = ST_WR_ADDR;
              end else if (RX_P_DATA == DATA_WIDTH'(CMD_RD)) begin
                state_d = ST_RD_ADDR;
              end else begin
                err_v_d    = 1'b1;
                err_code_d = ERR_CMD;
              end
            end
            ST_WR_ADDR: begin
              addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
              state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
              wr_data_d = RX_P_DATA;
              wr_en_d   = 1'b1;
              state_d   = ST_IDLE;
            end
            ST_RD_ADDR: begin
              addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
              rd_en_d = 1'b1;
              cnt_d   = CNT_ZERO;
              state_d = ST_RD_WAIT;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = state_q;
        end
      end
      ST_RD_WAIT: begin
        // Incoming UART bytes are ignored here; data has priority over timeout.
        if (RD_DATA_VLD) begin
          tx_data_d = RD_DATA;
          state_d   = ST_TX_SEND;
        end else if (cnt_q == CNT_MAX) begin
          state_d    = ST_IDLE;
          err_v_d    = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_TX_SEND: begin
        if (!TX_BUSY) begin
          tx_vld_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_TX_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign WR_EN     = wr_en_q;
  assign RD_EN     = rd_en_q;
  assign ADDR      = addr_q;
  assign WR_DATA   = wr_data_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign ERR_V     = err_v_q;
  assign ERR_CODE  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder.
// Inputs are driven on the falling edge; outputs are checked on the falling
// edge, half a cycle after the rising edge that updates them.
module tb_uart_cmd_decoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic       PAR_ERR = 1'b0;
  logic       STP_ERR = 1'b0;
  logic       WR_EN;
  logic       RD_EN;
  logic [3:0] ADDR;
  logic [7:0] WR_DATA;
  logic [7:0] RD_DATA = 8'h00;
  logic       RD_DATA_VLD = 1'b0;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       TX_BUSY = 1'b0;
  logic       ERR_V;
  logic [1:0] ERR_CODE;

  int checks = 0;
  int failures = 0;

  // Pulse counters, sampled at the rising edge (pre-update values).
  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0, both_cnt = 0;
  int wr_b, rd_b, tx_b, err_b;
  int k;

  uart_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR), .WR_EN(WR_EN), .RD_EN(RD_EN),
    .ADDR(ADDR), .WR_DATA(WR_DATA), .RD_DATA(RD_DATA), .RD_DATA_VLD(RD_DATA_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .ERR_V(ERR_V), .ERR_CODE(ERR_CODE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (WR_EN === 1'b1) wr_cnt = wr_cnt + 1;
    if (RD_EN === 1'b1) rd_cnt = rd_cnt + 1;
    if (TX_D_VLD === 1'b1) tx_cnt = tx_cnt + 1;
    if (ERR_V === 1'b1) err_cnt = err_cnt + 1;
    if (WR_EN === 1'b1 && RD_EN === 1'b1) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic perr);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    PAR_ERR   = perr;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
    PAR_ERR   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic snap();
    wr_b = wr_cnt; rd_b = rd_cnt; tx_b = tx_cnt; err_b = err_cnt;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wr_en"}, WR_EN, 0);
    check({tag, "_rd_en"}, RD_EN, 0);
    check({tag, "_addr"}, ADDR, 0);
    check({tag, "_wr_data"}, WR_DATA, 0);
    check({tag, "_tx_data"}, TX_P_DATA, 0);
    check({tag, "_tx_vld"}, TX_D_VLD, 0);
    check({tag, "_err_v"}, ERR_V, 0);
    check({tag, "_err_code"}, ERR_CODE, 0);
  endtask

  initial begin
    // Reset state
    idle(2);
    check_zero_outputs("reset");
    RST = 1'b0;
    idle(2);

    // Write AA,03,5C
    snap();
    send(8'hAA, 1'b0); send(8'h03, 1'b0); send(8'h5C, 1'b0);
    check("wr_en_pulse", WR_EN, 1);
    check("wr_addr", ADDR, 4'h3);
    check("wr_data", WR_DATA, 8'h5C);
    idle(2);
    check("wr_en_low_after", WR_EN, 0);
    check("wr_count", wr_cnt - wr_b, 1);
    check("wr_no_err", err_cnt - err_b, 0);

    // Read BB,07 with data 3 cycles after RD_EN, transmitter idle
    snap();
    send(8'hBB, 1'b0); send(8'h07, 1'b0);
    check("rd_en_pulse", RD_EN, 1);
    check("rd_addr", ADDR, 4'h7);
    idle(3);
    RD_DATA = 8'hE1; RD_DATA_VLD = 1'b1;
    @(negedge CLK);
    RD_DATA_VLD = 1'b0;
    k = 0;
    while (TX_D_VLD !== 1'b1 && k < 6) begin @(negedge CLK); k++; end
    check("tx_vld_seen", TX_D_VLD, 1);
    check("tx_data", TX_P_DATA, 8'hE1);
    idle(3);
    check("tx_count", tx_cnt - tx_b, 1);
    check("rd_count", rd_cnt - rd_b, 1);
    check("rd_no_err", err_cnt - err_b, 0);

    // Read with transmitter busy 10 cycles; a stray byte during it is dropped
    snap();
    TX_BUSY = 1'b1;
    send(8'hBB, 1'b0); send(8'h07, 1'b0);
    idle(3);
    RD_DATA = 8'h3C; RD_DATA_VLD = 1'b1;
    @(negedge CLK);
    RD_DATA_VLD = 1'b0;
    send(8'h42, 1'b0);
    idle(7);
    check("busy_tx_withheld", tx_cnt - tx_b, 0);
    check("busy_tx_data_stable", TX_P_DATA, 8'h3C);
    check("busy_byte_dropped", err_cnt - err_b, 0);
    TX_BUSY = 1'b0;
    k = 0;
    while (TX_D_VLD !== 1'b1 && k < 6) begin @(negedge CLK); k++; end
    check("busy_tx_vld_seen", TX_D_VLD, 1);
    check("busy_tx_data", TX_P_DATA, 8'h3C);
    idle(3);
    check("busy_tx_count", tx_cnt - tx_b, 1);

    // Parity error on address byte aborts, then a clean write
    snap();
    send(8'hAA, 1'b0); send(8'h02, 1'b1);
    check("frame_err_v", ERR_V, 1);
    check("frame_err_code", ERR_CODE, 2'b10);
    send(8'hAA, 1'b0); send(8'h02, 1'b0); send(8'h11, 1'b0);
    check("after_frame_wr_en", WR_EN, 1);
    check("after_frame_addr", ADDR, 4'h2);
    check("after_frame_data", WR_DATA, 8'h11);
    idle(2);
    check("frame_wr_count", wr_cnt - wr_b, 1);
    check("frame_err_count", err_cnt - err_b, 1);

    // Bad command byte, stray read return in IDLE, then a read timeout
    snap();
    send(8'h42, 1'b0);
    check("cmd_err_v", ERR_V, 1);
    check("cmd_err_code", ERR_CODE, 2'b01);
    RD_DATA = 8'h99; RD_DATA_VLD = 1'b1;
    @(negedge CLK);
    RD_DATA_VLD = 1'b0;
    idle(3);
    check("cmd_err_code_held", ERR_CODE, 2'b01);
    check("stray_rd_vld_no_tx", tx_cnt - tx_b, 0);
    send(8'hBB, 1'b0); send(8'h01, 1'b0);
    check("to_rd_en", RD_EN, 1);
    k = 0;
    while (ERR_V !== 1'b1 && k < 40) begin @(negedge CLK); k++; end
    check("to_err_v", ERR_V, 1);
    check("to_err_code", ERR_CODE, 2'b11);
    check("to_latency_16_18", (k >= 16 && k <= 18), 1);
    // state back in IDLE: a write now completes normally
    send(8'hAA, 1'b0); send(8'h09, 1'b0); send(8'h77, 1'b0);
    check("to_then_wr_en", WR_EN, 1);
    check("to_then_wr_data", WR_DATA, 8'h77);
    idle(2);
    check("to_no_tx", tx_cnt - tx_b, 0);

    // Reset between AA and address byte
    send(8'hAA, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_zero_outputs("midrst");
    RST = 1'b0;
    idle(1);
    snap();
    send(8'h05, 1'b0);
    check("midrst_b1_err_code", ERR_CODE, 2'b01);
    send(8'h66, 1'b0);
    check("midrst_b2_err_v", ERR_V, 1);
    check("midrst_b2_err_code", ERR_CODE, 2'b01);
    idle(2);
    check("midrst_no_wr", wr_cnt - wr_b, 0);
    check("midrst_err_count", err_cnt - err_b, 2);

    check("never_wr_and_rd", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
